ct_f_spsram_arb_ctrl: RTL and testbench
=======================================

Name: ct_f_spsram_arb_ctrl

Overview:
- Access controller for one single-port SRAM macro (default 2048x144, active-low CEN/GWEN/per-bit WEN; read data valid one cycle after the read command).
- Shares the single port between a write requester (fill) and a read requester (lookup) using round-robin arbitration.
- Returns read data with a valid strobe.
- Optionally zero-initialises the whole array after reset before accepting any request.

Parameters:
ADDR_WIDTH, 11, SRAM address width
DATA_WIDTH, 144, SRAM data width
DEPTH, 2**ADDR_WIDTH, number of entries swept by init (derived, do not override)

Ports:
forever_cpuclk  input  1  clock, also clocks the SRAM
cpurst_b  input  1  asynchronous active-low reset
wr_req  input  1  write request; held with payload until wr_gnt
wr_addr  input  ADDR_WIDTH  write address
wr_data  input  DATA_WIDTH  write data
wr_bwe  input  DATA_WIDTH  per-bit write enable, active-high
wr_gnt  output  1  write accepted this cycle
rd_req  input  1  read request; held with address until rd_gnt
rd_addr  input  ADDR_WIDTH  read address
rd_gnt  output  1  read accepted this cycle
rd_data_vld  output  1  rd_data valid; one-cycle pulse
rd_data  output  DATA_WIDTH  read data
init_done  output  1  array ready; requests are accepted only when high
ram_a  output  ADDR_WIDTH  SRAM A
ram_cen  output  1  SRAM CEN (active-low)
ram_gwen  output  1  SRAM GWEN (active-low, 0 = write)
ram_wen  output  DATA_WIDTH  SRAM WEN (active-low per bit)
ram_d  output  DATA_WIDTH  SRAM D
ram_q  input  DATA_WIDTH  SRAM Q

Behaviour:
- Clock and reset: one clock, forever_cpuclk; cpurst_b is asynchronous, active-low.
- Flops and reset values:
  - state: resets to INIT (or IDLE without the macro).
  - init_cnt: 0.
  - last_gnt: 1 = write, so a read wins the first tie.
  - rd_pend: 0.
- Output values during reset:
  - wr_gnt = rd_gnt = 0, rd_data_vld = 0.
  - ram_cen = 1, ram_gwen = 1, ram_wen = all ones, ram_a = 0, ram_d = 0.
  - init_done = 0 (macro on) or 1 (macro off).
- State INIT:
  - Each cycle drive ram_cen = 0, ram_gwen = 0, ram_wen = 0, ram_d = 0, ram_a = init_cnt; then init_cnt++.
  - After the cycle with init_cnt = DEPTH-1, go to IDLE. There is no wrap; the counter is never reused.
  - wr_gnt and rd_gnt are held at 0; requests wait.
- State IDLE (arbitration): grants are combinational in the same cycle as the request.
  - Only wr_req: wr_gnt = 1.
  - Only rd_req: rd_gnt = 1.
  - Both: grant the requester not named in last_gnt. last_gnt updates on every grant.
  - Never both grants in one cycle.
- Write grant drives:
  - ram_cen = 0, ram_gwen = 0, ram_a = wr_addr, ram_d = wr_data, ram_wen = ~wr_bwe.
  - wr_bwe = 0 is still a granted access that writes no bits.
- Read grant drives:
  - ram_cen = 0, ram_gwen = 1, ram_a = rd_addr, ram_wen = all ones.
  - rd_pend is set for one cycle.
- No grant: ram_cen = 1, ram_gwen = 1, ram_wen = all ones.
- Read latency:
  - rd_data_vld = rd_pend, i.e. exactly one cycle after rd_gnt.
  - rd_data = ram_q, unregistered. rd_data is don't-care when rd_data_vld = 0.
- Back-to-back:
  - One access per cycle at full throughput.
  - Consecutive reads give consecutive rd_data_vld pulses.
- Same-address hazards:
  - A read granted in the cycle after a write returns the new data.
  - A read granted before a write returns the old data.
  - The write and read cannot collide in one cycle.
- Reset mid-operation: a pending read is dropped (rd_pend cleared, no rd_data_vld). With the macro on, init restarts from address 0.
- init_done = (state == IDLE).

Optional Feature:
CT_SPSRAM_ARB_INIT_EN
- Defined: INIT state and init_cnt exist; sweep takes DEPTH cycles (2048 by default) after reset deasserts; init_done rises the cycle after the write of address DEPTH-1.
- Undefined: no INIT state and no counter; state resets to IDLE; init_done is tied to 1; array contents after reset are undefined.

Test Plan:
- Init (macro on): release reset -> 2048 consecutive write cycles, addresses 0..2047, D = 0, WEN = 0; init_done = 1 at cycle 2048. A read of address 0x7FF then returns 0.
- Single write then read: write addr 0x155, data 0x5A5A..., bwe all ones; next cycle read 0x155 -> rd_gnt same cycle as request; rd_data_vld one cycle later with data 0x5A5A....
- Partial write: bwe = 0x0...FF with data all ones over a zeroed entry -> read returns 0x0...FF.
- Contention: wr_req and rd_req both held high for 4 cycles after init -> grant order rd, wr, rd, wr; never both grants; each request holds until granted.
- Reset during read: assert cpurst_b low in the cycle after rd_gnt -> no rd_data_vld; all ram_* outputs at their idle values; init restarts at address 0 (macro on).
- Macro off: release reset -> init_done = 1 immediately; wr_req in the first cycle gets wr_gnt in the same cycle.

Source files
------------

// File: rtl/ct_f_spsram_arb_ctrl.sv
// Single-port SRAM access controller: round-robin arbitration between a fill writer and a lookup reader.
// Optional post-reset zero sweep of the whole array is enabled by defining CT_SPSRAM_ARB_INIT_EN.
module ct_f_spsram_arb_ctrl #(
  parameter int ADDR_WIDTH = 11,
  parameter int DATA_WIDTH = 144
) (
  input  logic                  forever_cpuclk,
  input  logic                  cpurst_b,
  input  logic                  wr_req,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [DATA_WIDTH-1:0] wr_bwe,
  output logic                  wr_gnt,
  input  logic                  rd_req,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  rd_gnt,
  output logic                  rd_data_vld,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  init_done,
  output logic [ADDR_WIDTH-1:0] ram_a,
  output logic                  ram_cen,
  output logic                  ram_gwen,
  output logic [DATA_WIDTH-1:0] ram_wen,
  output logic [DATA_WIDTH-1:0] ram_d,
  input  logic [DATA_WIDTH-1:0] ram_q
);

  logic                  init_act;
  logic [ADDR_WIDTH-1:0] init_a;
  logic                  last_gnt_q, last_gnt_d;
  logic                  rd_pend_q;

`ifdef CT_SPSRAM_ARB_INIT_EN
  localparam int DEPTH = 2**ADDR_WIDTH;

  // state   | meaning
  // ST_INIT | sweeping zeros into every entry, requests held off
  // ST_IDLE | arbitrating wr/rd requests
  typedef enum logic {ST_INIT = 1'b0, ST_IDLE = 1'b1} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] init_cnt_q, init_cnt_d;

  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      state_q    <= ST_INIT;
      init_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
    end
  end

  // Counter stops at the last address; it is only reloaded by reset.
  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    if (state_q == ST_INIT) begin
      if (init_cnt_q == ADDR_WIDTH'(DEPTH - 1)) state_d = ST_IDLE;
      else init_cnt_d = init_cnt_q + 1'b1;
    end
  end

  assign init_done = (state_q == ST_IDLE);
  assign init_act  = (state_q == ST_INIT) && cpurst_b;
  assign init_a    = init_cnt_q;
`else
  assign init_done = 1'b1;
  assign init_act  = 1'b0;
  assign init_a    = '0;
`endif

  // Gating with cpurst_b keeps the SRAM port quiet while reset is held.
  always_comb begin
    wr_gnt     = 1'b0;
    rd_gnt     = 1'b0;
    ram_cen    = 1'b1;
    ram_gwen   = 1'b1;
    ram_wen    = '1;
    ram_a      = '0;
    ram_d      = '0;
    last_gnt_d = last_gnt_q;
    if (init_act) begin
      ram_cen  = 1'b0;
      ram_gwen = 1'b0;
      ram_wen  = '0;
      ram_a    = init_a;
    end else if (cpurst_b && init_done) begin
      if (wr_req && rd_req) begin
        rd_gnt = last_gnt_q;
        wr_gnt = !last_gnt_q;
      end else begin
        wr_gnt = wr_req;
        rd_gnt = rd_req;
      end
      if (wr_gnt) begin
        ram_cen    = 1'b0;
        ram_gwen   = 1'b0;
        ram_a      = wr_addr;
        ram_d      = wr_data;
        ram_wen    = ~wr_bwe;
        last_gnt_d = 1'b1;
      end else if (rd_gnt) begin
        ram_cen    = 1'b0;
        ram_a      = rd_addr;
        last_gnt_d = 1'b0;
      end
    end
  end

  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      last_gnt_q <= 1'b1;
      rd_pend_q  <= 1'b0;
    end else begin
      last_gnt_q <= last_gnt_d;
      rd_pend_q  <= rd_gnt;
    end
  end

  assign rd_data_vld = rd_pend_q;
  assign rd_data     = ram_q;

endmodule

// File: tb/tb_ct_f_spsram_arb_ctrl.sv
// Bench for ct_f_spsram_arb_ctrl: SRAM model, directed cases and random traffic against a memory/arbiter model.
// Works with or without CT_SPSRAM_ARB_INIT_EN.
module tb_ct_f_spsram_arb_ctrl;
  localparam int AW = 11;
  localparam int DW = 144;

  logic          clk = 1'b0;
  logic          rst_b;
  logic          wr_req, rd_req;
  logic [AW-1:0] wr_addr, rd_addr;
  logic [DW-1:0] wr_data, wr_bwe;
  logic          wr_gnt, rd_gnt, rd_data_vld, init_done;
  logic [DW-1:0] rd_data;
  logic [AW-1:0] ram_a;
  logic          ram_cen, ram_gwen;
  logic [DW-1:0] ram_wen, ram_d, ram_q;

  int n_chk = 0;
  int n_fail = 0;

  logic [DW-1:0] mem [2**AW];
  logic [DW-1:0] ref_mem [int];
  bit            mem_zero = 1'b0;
  bit            last_wr = 1'b1;
  bit            pend_vld = 1'b0;
  bit            pend_known = 1'b0;
  logic [DW-1:0] pend_data;

  always #5 clk = ~clk;

  ct_f_spsram_arb_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .forever_cpuclk(clk), .cpurst_b(rst_b),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_bwe(wr_bwe), .wr_gnt(wr_gnt),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt),
    .rd_data_vld(rd_data_vld), .rd_data(rd_data), .init_done(init_done),
    .ram_a(ram_a), .ram_cen(ram_cen), .ram_gwen(ram_gwen), .ram_wen(ram_wen),
    .ram_d(ram_d), .ram_q(ram_q)
  );

  // Behavioural single-port SRAM: one-cycle read latency, per-bit active-low write enables
  always @(posedge clk) begin
    if (ram_cen === 1'b0) begin
      if (ram_gwen === 1'b0) mem[ram_a] <= (mem[ram_a] & ram_wen) | (ram_d & ~ram_wen);
      else ram_q <= mem[ram_a];
    end
  end

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] rand_data();
    logic [DW-1:0] r = '0;
    for (int i = 0; i < 5; i++) r = {r[DW-33:0], 32'($urandom())};
    return r;
  endfunction

  task automatic lookup(input logic [AW-1:0] a, output bit known, output logic [DW-1:0] d);
    if (ref_mem.exists(int'(a))) begin known = 1'b1; d = ref_mem[int'(a)]; end
    else if (mem_zero) begin known = 1'b1; d = '0; end
    else begin known = 1'b0; d = 'x; end
  endtask

  // One clock from posedge+1 to the next posedge+1; checks taken at the negedge
  task automatic cycle(output bit wg, output bit rg);
    bit ewg, erg, known;
    logic [DW-1:0] old;
    @(negedge clk);
    if (wr_req && rd_req) begin erg = last_wr; ewg = !last_wr; end
    else begin ewg = wr_req; erg = rd_req; end
    chk("wr_gnt", DW'(wr_gnt), DW'(ewg));
    chk("rd_gnt", DW'(rd_gnt), DW'(erg));
    chk("gnt_excl", DW'(wr_gnt & rd_gnt), '0);
    chk("rd_data_vld", DW'(rd_data_vld), DW'(pend_vld));
    if (pend_vld && pend_known) chk("rd_data", rd_data, pend_data);
    chk("ram_cen", DW'(ram_cen), DW'(!(ewg || erg)));
    chk("ram_gwen", DW'(ram_gwen), DW'(!ewg));
    if (ewg) begin
      chk("ram_a_wr", DW'(ram_a), DW'(wr_addr));
      chk("ram_d_wr", ram_d, wr_data);
      chk("ram_wen_wr", ram_wen, ~wr_bwe);
      lookup(wr_addr, known, old);
      if (known) ref_mem[int'(wr_addr)] = (old & ~wr_bwe) | (wr_data & wr_bwe);
      else if (&wr_bwe) ref_mem[int'(wr_addr)] = wr_data;
    end else if (erg) begin
      chk("ram_a_rd", DW'(ram_a), DW'(rd_addr));
      chk("ram_wen_rd", ram_wen, '1);
    end
    pend_vld = erg;
    if (erg) lookup(rd_addr, pend_known, pend_data);
    if (ewg || erg) last_wr = ewg;
    wg = (wr_gnt === 1'b1);
    rg = (rd_gnt === 1'b1);
    @(posedge clk); #1;
  endtask

  task automatic do_wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [DW-1:0] be,
                       output int lat);
    bit wg, rg;
    wr_req = 1'b1; wr_addr = a; wr_data = d; wr_bwe = be; lat = 0;
    do begin cycle(wg, rg); lat++; end while (!wg && lat < 8);
    chk("wr_granted", DW'(wg), DW'(1));
    wr_req = 1'b0;
  endtask

  task automatic do_rd(input logic [AW-1:0] a, output int lat);
    bit wg, rg;
    rd_req = 1'b1; rd_addr = a; lat = 0;
    do begin cycle(wg, rg); lat++; end while (!rg && lat < 8);
    chk("rd_granted", DW'(rg), DW'(1));
    rd_req = 1'b0;
  endtask

  task automatic idle(input int n);
    bit wg, rg;
    for (int i = 0; i < n; i++) cycle(wg, rg);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  lat;
    int  errs;
    bit  wg, rg;
    logic exp_done;
`ifdef CT_SPSRAM_ARB_INIT_EN
    exp_done = 1'b0;
`else
    exp_done = 1'b1;
`endif
    rst_b = 1'b0;
    wr_req = 1'b1; wr_addr = 11'h155; wr_data = {18{8'h5A}}; wr_bwe = '1;
    rd_req = 1'b1; rd_addr = 11'h155;
    #12;
    chk("rst_wr_gnt", DW'(wr_gnt), '0);
    chk("rst_rd_gnt", DW'(rd_gnt), '0);
    chk("rst_vld", DW'(rd_data_vld), '0);
    chk("rst_cen", DW'(ram_cen), DW'(1));
    chk("rst_gwen", DW'(ram_gwen), DW'(1));
    chk("rst_wen", ram_wen, '1);
    chk("rst_a", DW'(ram_a), '0);
    chk("rst_d", ram_d, '0);
    chk("rst_init_done", DW'(init_done), DW'(exp_done));
    rd_req = 1'b0;
    @(posedge clk); #1;
    rst_b = 1'b1;

`ifdef CT_SPSRAM_ARB_INIT_EN
    errs = 0;
    for (int k = 0; k < 2**AW; k++) begin
      @(negedge clk);
      if (k == 0) chk("init_first_a", DW'(ram_a), '0);
      if (k == 2**AW - 1) chk("init_last_a", DW'(ram_a), DW'(2**AW - 1));
      if (ram_a !== AW'(k) || ram_cen !== 1'b0 || ram_gwen !== 1'b0 || ram_wen !== '0 ||
          ram_d !== '0 || wr_gnt !== 1'b0 || rd_gnt !== 1'b0 || init_done !== 1'b0) errs++;
      @(posedge clk); #1;
    end
    chk("init_sweep_errs", DW'(errs), '0);
    chk("init_done_after", DW'(init_done), DW'(1));
    mem_zero = 1'b1;
`else
    errs = 0;
    chk("init_done_off", DW'(init_done), DW'(1));
`endif

    // Directed: write, immediate read-back, array-end read, partial write
    do_wr(11'h155, {18{8'h5A}}, '1, lat);
    chk("first_wr_lat", DW'(lat), DW'(1));
    do_rd(11'h155, lat);
    chk("rd_same_cycle", DW'(lat), DW'(1));
    do_rd(11'h7FF, lat);
    do_wr(11'h0AA, '0, '1, lat);
    do_wr(11'h0AA, '1, DW'(8'hFF), lat);
    do_rd(11'h0AA, lat);
    do_wr(11'h300, rand_data(), '1, lat);

    // Contention: last grant was a write, so reads win the first tie
    wr_req = 1'b1; wr_addr = 11'h010; wr_data = rand_data(); wr_bwe = '1;
    rd_req = 1'b1; rd_addr = 11'h155;
    for (int k = 0; k < 4; k++) begin
      cycle(wg, rg);
      chk("cont_rd_order", DW'(rg), DW'(k % 2 == 0));
      chk("cont_wr_order", DW'(wg), DW'(k % 2 == 1));
      if (wg) begin wr_addr = 11'h011 + AW'(k); wr_data = rand_data(); end
      if (rg) rd_addr = 11'h010;
    end
    wr_req = 1'b0; rd_req = 1'b0;
    idle(2);

    // Random traffic over a small address window to provoke same-address hazards
    for (int c = 0; c < 600; c++) begin
      if (!wr_req && $urandom_range(1, 0) == 1) begin
        wr_req = 1'b1; wr_addr = AW'($urandom_range(15, 0)); wr_data = rand_data();
        wr_bwe = ($urandom_range(1, 0) == 1) ? {DW{1'b1}} : rand_data();
      end
      if (!rd_req && $urandom_range(1, 0) == 1) begin
        rd_req = 1'b1; rd_addr = AW'($urandom_range(15, 0));
      end
      cycle(wg, rg);
      if (wg) wr_req = 1'b0;
      if (rg) rd_req = 1'b0;
    end
    wr_req = 1'b0; rd_req = 1'b0;
    idle(2);

    // Reset in the cycle after a read grant drops the pending read
    do_rd(11'h155, lat);
    rst_b = 1'b0;
    wr_req = 1'b1; wr_addr = 11'h020;
    #1;
    chk("mid_rst_vld", DW'(rd_data_vld), '0);
    chk("mid_rst_cen", DW'(ram_cen), DW'(1));
    chk("mid_rst_gwen", DW'(ram_gwen), DW'(1));
    chk("mid_rst_wen", ram_wen, '1);
    chk("mid_rst_a", DW'(ram_a), '0);
    chk("mid_rst_d", ram_d, '0);
    chk("mid_rst_wr_gnt", DW'(wr_gnt), '0);
    chk("mid_rst_init_done", DW'(init_done), DW'(exp_done));
    wr_req = 1'b0;
    @(posedge clk); #1;
    rst_b = 1'b1;
    @(negedge clk);
    chk("post_rst_vld", DW'(rd_data_vld), '0);
`ifdef CT_SPSRAM_ARB_INIT_EN
    chk("reinit_a", DW'(ram_a), '0);
    chk("reinit_cen", DW'(ram_cen), '0);
`else
    chk("post_rst_cen", DW'(ram_cen), DW'(1));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
